// File: rtl/led_sched_pkg.sv
// rtl/led_sched_pkg.sv - shared types and colour constants for the LED scheduler
package led_sched_pkg;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } colour_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam colour_t OFF     = 3'b000;
    localparam colour_t RED     = 3'b100;
    localparam colour_t GREEN   = 3'b010;
    localparam colour_t BLUE    = 3'b001;
    localparam colour_t YELLOW  = 3'b110;
    localparam colour_t CYAN    = 3'b011;
    localparam colour_t MAGENTA = 3'b101;
    localparam colour_t WHITE   = 3'b111;

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - prescaler producing a one-cycle tick every TICK_DIV clocks
module led_tick_gen #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] count_q, count_d;

    assign tick_o = (count_q == CW'(TICK_DIV - 1));

    always_comb begin
        if (clr_i || tick_o) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_colour_scheduler.sv
// rtl/led_colour_scheduler.sv - round-robin time-slicing of one RGB LED between requesters
module led_colour_scheduler
    import led_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TICK_DIV    = 10_000_000,
    parameter int SLOT_TICKS  = 10,
    parameter int GAP_TICKS   = 2,
    parameter int BLINK_TICKS = 2
) (
    input  logic                   clock_100mhz,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*3-1:0]   req_colour,
    input  logic [NUM_REQ-1:0]     req_blink,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   red,
    output logic                   green,
    output logic                   blue
);

    localparam int OW   = $clog2(NUM_REQ);
    localparam int CMAX = (SLOT_TICKS > GAP_TICKS) ? SLOT_TICKS : GAP_TICKS;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(BLINK_TICKS + 1);

    state_t              state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       last_q, last_d;
    colour_t             colour_q, colour_d;
    logic                blink_q, blink_d;
    logic                phase_q, phase_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                busy_q, busy_d;
    colour_t             rgb_q, rgb_d;
    logic                run_q;

    logic                tick;
    logic                enter;
    logic                do_grant;
    logic                do_idle;
    logic [OW-1:0]       winner;
    colour_t             colours [NUM_REQ];

    function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [OW-1:0]      last);
        logic [OW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && r[OW'(idx)]) begin
                pick  = OW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            colours[i] = colour_t'(req_colour[i*3 +: 3]);
        end
    end

    assign winner = rr_pick(req, last_q);

    // Every state entry (including SHOW->SHOW re-grant) restarts the prescaler
    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i  (clock_100mhz),
        .rst_ni (reset_n),
        .clr_i  (enter),
        .tick_o (tick)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        colour_d = colour_q;
        blink_d  = blink_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        bcnt_d   = bcnt_q;
        enter    = 1'b0;
        do_grant = 1'b0;
        do_idle  = 1'b0;

        case (state_q)
            IDLE: begin
                do_grant = run_q && (|req);
            end
            SHOW: begin
                if (tick && blink_q) begin
                    if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
                        bcnt_d  = '0;
                        phase_d = ~phase_q;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
                if (!req[owner_q] || (tick && cnt_q == CW'(1))) begin
                    if (GAP_TICKS == 0) begin
                        do_grant = |req;
                        do_idle  = ~|req;
                    end else begin
                        state_d = GAP;
                        cnt_d   = CW'(GAP_TICKS);
                        enter   = 1'b1;
                    end
                end else if (tick) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (tick && cnt_q == CW'(1)) begin
                    do_grant = |req;
                    do_idle  = ~|req;
                end else if (tick) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: do_idle = 1'b1;
        endcase

        if (do_grant) begin
            state_d  = SHOW;
            owner_d  = winner;
            last_d   = winner;
            colour_d = colours[winner];
            blink_d  = req_blink[winner];
            phase_d  = 1'b1;
            bcnt_d   = '0;
            cnt_d    = CW'(SLOT_TICKS);
            enter    = 1'b1;
        end
        if (do_idle) begin
            state_d = IDLE;
            cnt_d   = '0;
            enter   = 1'b1;
        end

        grant_d = (state_d == SHOW) ? (NUM_REQ'(1) << owner_d) : '0;
        busy_d  = (state_d != IDLE);
        rgb_d   = (state_d == SHOW && (!blink_d || phase_d)) ? colour_d : OFF;
    end

    // run_q holds off arbitration for the first edge after reset release
    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            last_q   <= OW'(NUM_REQ - 1);
            colour_q <= OFF;
            blink_q  <= 1'b0;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            bcnt_q   <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            rgb_q    <= OFF;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            colour_q <= colour_d;
            blink_q  <= blink_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            bcnt_q   <= bcnt_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            rgb_q    <= rgb_d;
            run_q    <= 1'b1;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign red   = rgb_q.r;
    assign green = rgb_q.g;
    assign blue  = rgb_q.b;

endmodule

// File: tb/tb_led_colour_scheduler.sv
// tb/tb_led_colour_scheduler.sv - self-checking bench for led_colour_scheduler
module tb_led_colour_scheduler;
    import led_sched_pkg::*;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int SLOT  = 3;
    localparam int GAPT  = 1;
    localparam int BLINK = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N*3-1:0] req_colour;
    logic [N-1:0] req_blink;
    logic [N-1:0] grant;
    logic         busy, red, green, blue;
    logic [2:0]   rgb;

    int checks = 0;
    int errors = 0;

    int         m_mode;
    int         m_el;
    logic [1:0] m_owner, m_last;
    bit         m_armed, m_blink;
    logic [2:0] m_colour;
    logic [N-1:0] e_grant;
    logic       e_busy;
    logic [2:0] e_rgb;

    assign rgb = {red, green, blue};

    always #5 clk = ~clk;

    led_colour_scheduler #(
        .NUM_REQ     (N),
        .TICK_DIV    (DIV),
        .SLOT_TICKS  (SLOT),
        .GAP_TICKS   (GAPT),
        .BLINK_TICKS (BLINK)
    ) dut (
        .clock_100mhz (clk),
        .reset_n      (rst_n),
        .req          (req),
        .req_colour   (req_colour),
        .req_blink    (req_blink),
        .grant        (grant),
        .busy         (busy),
        .red          (red),
        .green        (green),
        .blue         (blue)
    );

    task automatic model_outputs();
        e_grant = (m_mode == 1) ? N'(1 << m_owner) : '0;
        e_busy  = (m_mode != 0);
        e_rgb   = (m_mode == 1 && (!m_blink || ((m_el / (BLINK * DIV)) % 2 == 0))) ? m_colour : 3'b000;
    endtask

    task automatic model_reset();
        m_mode = 0; m_el = 0; m_owner = 0; m_last = 2'(N - 1);
        m_armed = 0; m_blink = 0; m_colour = 0;
        model_outputs();
    endtask

    // Time-based view: a slot is SLOT*DIV cycles, a gap GAPT*DIV cycles
    task automatic model_step();
        bit do_grant = 0;
        bit do_idle  = 0;
        bit found    = 0;
        logic [1:0] cand;
        case (m_mode)
            0: do_grant = m_armed && (req != 0);
            1: begin
                if (!req[m_owner] || (m_el + 1 == SLOT * DIV)) begin
                    if (GAPT == 0) begin do_grant = (req != 0); do_idle = (req == 0); end
                    else begin m_mode = 2; m_el = 0; end
                end else m_el++;
            end
            default: begin
                if (m_el + 1 == GAPT * DIV) begin do_grant = (req != 0); do_idle = (req == 0); end
                else m_el++;
            end
        endcase
        m_armed = 1;
        if (do_grant) begin
            for (int k = 1; k <= N; k++) begin
                cand = 2'((int'(m_last) + k) % N);
                if (!found && req[cand]) begin m_owner = cand; found = 1; end
            end
            m_last = m_owner; m_colour = req_colour[m_owner*3 +: 3];
            m_blink = req_blink[m_owner]; m_mode = 1; m_el = 0;
        end
        if (do_idle) begin m_mode = 0; m_el = 0; end
        model_outputs();
    endtask

    task automatic clk_step();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        req = '0;
        while (busy !== 1'b0 && n < 100) begin clk_step(); n++; end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        bit ok;
        checks++;
        if ({grant, busy, rgb} !== 8'h00) begin errors++; $display("FAIL reset_init got %b exp 00000000", {grant, busy, rgb}); end
        rst_n = 1'b1; req = 4'b0100; req_colour[2*3 +: 3] = RED;
        clk_step();
        checks++;
        if (grant !== 4'b0000) begin errors++; $display("FAIL reset_arm got %b exp 0000", grant); end
        clk_step();
        checks++;
        if ({grant, busy, rgb} !== {4'b0100, 1'b1, 3'b100}) begin errors++; $display("FAIL reset_first_grant got %b exp 01001100", {grant, busy, rgb}); end
        repeat (3) clk_step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, busy, rgb} !== 8'h00) begin errors++; $display("FAIL reset_async got %b exp 00000000", {grant, busy, rgb}); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clk_step();
        checks++;
        if (grant !== 4'b0000) begin errors++; $display("FAIL reset_rel_edge1 got %b exp 0000", grant); end
        clk_step();
        checks++;
        if (grant !== 4'b0100) begin errors++; $display("FAIL reset_rel_edge2 got %b exp 0100", grant); end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reset_drain got busy=%b exp 0", busy); end
    endtask

    task automatic test_early_release();
        int n = 0;
        bit ok;
        req = 4'b1000; req_colour[3*3 +: 3] = CYAN;
        clk_step();
        checks++;
        if (grant !== 4'b1000) begin errors++; $display("FAIL early_grant got %b exp 1000", grant); end
        repeat (4) clk_step();
        req = '0;
        clk_step();
        checks++;
        if ({grant, busy, rgb} !== {4'b0000, 1'b1, 3'b000}) begin errors++; $display("FAIL early_drop got %b exp 00001000", {grant, busy, rgb}); end
        while (busy === 1'b1 && n < 50) begin n++; clk_step(); end
        checks++;
        if (n != 4 || grant !== 4'b0000) begin errors++; $display("FAIL early_gap_len got %0d/%b exp 4/0000", n, grant); end
        wait_idle(ok);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [4];
        int gap, len;
        bit ok;
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0001;
        req = 4'b1011;
        for (int s = 0; s < 4; s++) begin
            gap = 0;
            while (grant === 4'b0000 && gap < 50) begin gap++; clk_step(); end
            checks++;
            if (grant !== exp_seq[s]) begin errors++; $display("FAIL rr_order slot %0d got %b exp %b", s, grant, exp_seq[s]); end
            if (s > 0) begin
                checks++;
                if (gap != 4) begin errors++; $display("FAIL rr_gap slot %0d got %0d exp 4", s, gap); end
            end
            len = 0;
            while (grant === exp_seq[s] && len < 50) begin len++; clk_step(); end
            checks++;
            if (len != 12) begin errors++; $display("FAIL rr_len slot %0d got %0d exp 12", s, len); end
        end
        wait_idle(ok);
    endtask

    task automatic test_single();
        int len = 0, gap = 0;
        bit ok;
        req = 4'b0010; req_colour[1*3 +: 3] = RED; req_blink = '0;
        clk_step();
        while (grant === 4'b0010 && rgb === 3'b100 && len < 50) begin len++; clk_step(); end
        checks++;
        if (len != 12) begin errors++; $display("FAIL single_len got %0d exp 12", len); end
        while (grant === 4'b0000 && busy === 1'b1 && rgb === 3'b000 && gap < 50) begin gap++; clk_step(); end
        checks++;
        if (gap != 4) begin errors++; $display("FAIL single_gap got %0d exp 4", gap); end
        checks++;
        if ({grant, rgb} !== {4'b0010, 3'b100}) begin errors++; $display("FAIL single_regrant got %b exp 0010100", {grant, rgb}); end
        wait_idle(ok);
    endtask

    task automatic test_blink();
        logic [2:0] exp_rgb;
        bit ok;
        req = 4'b0001; req_colour[2:0] = GREEN; req_blink = 4'b0001;
        clk_step();
        for (int c = 0; c < 12; c++) begin
            exp_rgb = ((c / 4) % 2 == 0) ? GREEN : OFF;
            checks++;
            if ({grant, rgb} !== {4'b0001, exp_rgb}) begin errors++; $display("FAIL blink cyc %0d got %b exp %b", c, {grant, rgb}, {4'b0001, exp_rgb}); end
            clk_step();
        end
        checks++;
        if ({grant, busy, rgb} !== {4'b0000, 1'b1, 3'b000}) begin errors++; $display("FAIL blink_gap got %b exp 00001000", {grant, busy, rgb}); end
        req_blink = '0;
        wait_idle(ok);
    endtask

    task automatic test_latching();
        int n = 0, gap = 0;
        bit ok;
        req = 4'b0100; req_colour[2*3 +: 3] = BLUE;
        clk_step();
        checks++;
        if ({grant, rgb} !== {4'b0100, 3'b001}) begin errors++; $display("FAIL latch_start got %b exp 0100001", {grant, rgb}); end
        repeat (3) clk_step();
        req_colour[2*3 +: 3] = WHITE;
        while (grant === 4'b0100 && n < 50) begin
            checks++;
            if (rgb !== 3'b001) begin errors++; $display("FAIL latch_hold cyc %0d got %b exp 001", n, rgb); end
            n++; clk_step();
        end
        checks++;
        if (n != 9) begin errors++; $display("FAIL latch_rest_len got %0d exp 9", n); end
        while (grant === 4'b0000 && gap < 50) begin gap++; clk_step(); end
        checks++;
        if ({grant, rgb} !== {4'b0100, 3'b111}) begin errors++; $display("FAIL latch_next got %b exp 0100111", {grant, rgb}); end
        wait_idle(ok);
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            checks++;
            if ({grant, busy, rgb} !== {e_grant, e_busy, e_rgb}) begin
                errors++;
                if (errors < 20) $display("FAIL random cyc %0d got %b exp %b", c, {grant, busy, rgb}, {e_grant, e_busy, e_rgb});
            end
            if ($urandom_range(15) == 0) req = N'($urandom);
            if ($urandom_range(3) == 0) req_colour = (N*3)'($urandom);
            if ($urandom_range(15) == 0) req_blink = N'($urandom);
            clk_step();
        end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_colour = '0; req_blink = '0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        test_early_release();
        test_round_robin();
        test_single();
        test_blink();
        test_latching();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_colour_scheduler.md
Name: led_colour_scheduler

Overview:
- Shares the single on-board RGB status LED between NUM_REQ independent requesters, e.g. error, activity and heartbeat sources.
- Grants the LED round-robin for a fixed display slot, then forces a dark gap, and applies optional per-requester blinking.
- red/green/blue outputs drive the red/green/blue inputs of the existing colour LED dimmer/driver.
- Runs entirely on clock_100mhz.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TICK_DIV, 10_000_000, clock cycles per timing tick (100 ms at 100 MHz); must be ≥2.
- SLOT_TICKS, 10, ticks a granted colour is displayed; must be ≥1.
- GAP_TICKS, 2, dark ticks between slots; 0 allowed.
- BLINK_TICKS, 2, ticks per blink half-period; must be ≥1.

Ports:
- clock_100mhz  in  1  system clock
- reset_n  in  1  reset
- req  in  NUM_REQ  level request per requester
- req_colour  in  NUM_REQ x 3  packed {r,g,b} per requester
- req_blink  in  NUM_REQ  1 = blink the colour during its slot
- grant  out  NUM_REQ  one-hot current owner; all-zero when no owner
- busy  out  1  high in SHOW or GAP
- red  out  1  to LED driver
- green  out  1  to LED driver
- blue  out  1  to LED driver

Behaviour:
- Clock and reset:
  - One clock, clock_100mhz.
  - reset_n is asynchronous, active-low.
  - In reset: state IDLE; grant = 0; busy = 0; red/green/blue = 0; prescaler, slot and blink counters = 0; last_owner = NUM_REQ-1, so requester 0 wins first.
  - Reset asserted mid-slot forces these values immediately.
  - No output glitches after reset release.
- Outputs:
  - All outputs are registered.
  - Nothing is combinational from inputs to outputs.
- Tick:
  - Prescaler counts 0..TICK_DIV-1.
  - tick pulses for one cycle when the count = TICK_DIV-1.
  - Prescaler clears on every state entry, so each SHOW lasts exactly SLOT_TICKS*TICK_DIV cycles and each GAP lasts exactly GAP_TICKS*TICK_DIV cycles.
- IDLE:
  - Outputs dark; grant = 0.
  - If any req bit is high in cycle N, arbitrate round-robin: first requester with req high, searching from last_owner+1 upward with wrap.
  - On edge N+1:
    - state = SHOW; grant = one-hot winner; last_owner = winner.
    - Latch the winner's req_colour and req_blink.
    - Slot counter = SLOT_TICKS; blink phase = on.
    - red/green/blue = latched colour.
- SHOW:
  - Colour and blink mode are latched at grant; requester changes mid-slot are ignored.
  - If blink is set, the phase toggles every BLINK_TICKS ticks; LED shows the colour when the phase is on and is dark when off.
  - The slot counter decrements on tick.
  - At the tick where the counter reaches 0, exit SHOW.
  - If the owner drops req, exit SHOW on the next edge (early release).
  - Exit target is GAP, or directly back to arbitration if GAP_TICKS = 0.
- GAP:
  - grant = 0; LED dark; busy = 1.
  - After GAP_TICKS ticks: if any req is high, arbitrate exactly as in IDLE, on the same edge as GAP exit; otherwise go to IDLE.
- Arbitration:
  - A lone persistent requester re-wins every slot.
  - Requests arriving during SHOW/GAP wait; there is no pre-emption.
  - Colour 3'b000 is legal: the slot is shown dark but still granted.
- Counter widths:
  - $clog2 of the maximum count + 1.
  - No wrap-around is reachable within the legal parameter ranges.

Decomposition:
- Package led_sched_pkg:
  - colour_t (3-bit packed struct r,g,b).
  - state_t enum {IDLE, SHOW, GAP}.
  - Named colour constants: OFF, RED, GREEN, BLUE, YELLOW, CYAN, MAGENTA, WHITE.
- Sub-module led_tick_gen:
  - Parameterised prescaler with a synchronous clear input and a tick output.
- Top level holds the FSM, round-robin arbiter, slot/blink counters and output registers.

Test Plan:
(All scenarios use NUM_REQ=4, TICK_DIV=4, SLOT_TICKS=3, GAP_TICKS=1, BLINK_TICKS=1.)
- Reset: reset_n low mid-SHOW with req[2] high → grant=0, busy=0, rgb=000 immediately. After release with req[2] still high → grant=4'b0100 two edges later.
- Single requester: req[1]=1, colour RED, blink=0 → grant=0010 and rgb=100 for exactly 12 cycles, dark GAP for 4 cycles, then re-granted.
- Round-robin: req=4'b1011 held → grant sequence 0001, 0010, 1000, 0001, with a 4-cycle gap between slots.
- Blink: req[0] GREEN, blink=1 → green 4 cycles on, 4 off, 4 on, then GAP.
- Early release: drop req[3] 5 cycles into its slot → grant=0 and rgb dark next edge. GAP lasts 4 cycles, then IDLE with busy=0.
- Latching: change req_colour of the owner mid-slot from BLUE to WHITE → LED stays 001 until slot end. The next slot shows 111.
